// File: rtl/neuron_pkg.sv
// Shared types and constant helpers for the neuron multiply-accumulate block.
package neuron_pkg;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_BIAS  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Address width for a memory of n entries, never narrower than 1 bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Saturation limits as w-bit two's-complement patterns (callers truncate to w bits).
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/neuron_mac_weight_mem.sv
// Weight store: one write port, one registered read port (1-cycle latency).
module weight_mem #(
    parameter int DEPTH = 784,
    parameter int W     = 16,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    // No reset: contents must survive rst.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/neuron_mac.sv
// One neuron: streams numWeight activations against stored weights, saturating
// accumulate, adds bias and emits a one-cycle out_valid pulse with the sum.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int dataWidth      = 16,
    parameter int weightIntWidth = 4,
    parameter int numWeight      = 784
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [dataWidth-1:0]           in_data,
    input  logic                           wt_wr_en,
    input  logic [addr_w(numWeight)-1:0]   wt_wr_addr,
    input  logic [dataWidth-1:0]           wt_wr_data,
    input  logic                           bias_wr_en,
    input  logic [2*dataWidth-1:0]         bias_data,
    output logic                           out_valid,
    output logic [2*dataWidth-1:0]         out_sum
);

    localparam int AW = 2 * dataWidth;
    localparam int CW = addr_w(numWeight);
    localparam logic signed [AW-1:0] SAT_MAX = AW'(sat_max(AW));
    localparam logic signed [AW-1:0] SAT_MIN = AW'(sat_min(AW));

    // weightIntWidth only describes the fixed-point format for the activation stage.
    if (weightIntWidth < 1 || weightIntWidth > dataWidth) begin : g_bad_width
        $error("neuron_mac: weightIntWidth out of range");
    end

    function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] a,
                                                     input logic signed [AW-1:0] b);
        logic [AW:0] s;
        s = {a[AW-1], a} + {b[AW-1], b};
        if (s[AW] != s[AW-1]) return s[AW] ? SAT_MIN : SAT_MAX;
        return s[AW-1:0];
    endfunction

    state_t                  r_state, w_state_nxt;
    logic [CW-1:0]           r_in_cnt;
    logic [2:0]              r_vld;
    logic                    w_fire, w_last, w_wr_ok, w_drained;
    logic [dataWidth-1:0]    w_wt;
    logic signed [dataWidth-1:0] r_x0, r_a, r_b;
    logic signed [AW-1:0]    r_prod, r_acc, r_bias, r_out_sum;
    logic                    r_out_valid;

    assign in_ready  = (r_state == ST_ACC);
    assign w_fire    = in_valid & in_ready;
    assign w_last    = (r_in_cnt == CW'(numWeight - 1));
    assign w_wr_ok   = (r_state == ST_ACC) && (r_in_cnt == '0) && !w_fire;
    // Last product is in the add stage with nothing behind it.
    assign w_drained = r_vld[2] & ~r_vld[1] & ~r_vld[0];
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;

    weight_mem #(.DEPTH(numWeight), .W(dataWidth), .AW(CW)) u_wmem (
        .clk     (clk),
        .i_we    (wt_wr_en & w_wr_ok),
        .i_waddr (wt_wr_addr),
        .i_wdata (wt_wr_data),
        .i_re    (w_fire),
        .i_raddr (r_in_cnt),
        .o_rdata (w_wt)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_ACC;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACC:   if (w_fire && w_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drained) w_state_nxt = ST_BIAS;
            ST_BIAS:  w_state_nxt = ST_OUT;
            ST_OUT:   w_state_nxt = ST_ACC;
            default:  w_state_nxt = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_cnt    <= '0;
            r_vld       <= '0;
            r_acc       <= '0;
            r_bias      <= '0;
            r_out_sum   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_vld       <= {r_vld[1:0], w_fire};
            r_out_valid <= (r_state == ST_BIAS);
            if (w_fire) r_in_cnt <= w_last ? '0 : r_in_cnt + CW'(1);
            if (bias_wr_en && w_wr_ok) r_bias <= bias_data;
            if (r_vld[2]) r_acc <= sat_add(r_acc, r_prod);
            if (r_state == ST_BIAS) begin
                r_out_sum <= sat_add(r_acc, r_bias);
                r_acc     <= '0;
            end
        end
    end

    // Data stages carry no reset; r_vld qualifies them.
    always_ff @(posedge clk) begin
        if (w_fire) r_x0 <= in_data;
        if (r_vld[0]) begin
            r_a <= r_x0;
            r_b <= w_wt;
        end
        if (r_vld[1]) r_prod <= AW'(r_a) * AW'(r_b);
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac at numWeight=4, dataWidth=16.
module tb_neuron_mac;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        wt_wr_en = 1'b0;
    logic [1:0]  wt_wr_addr = '0;
    logic [15:0] wt_wr_data = '0;
    logic        bias_wr_en = 1'b0;
    logic [31:0] bias_data = '0;
    logic        out_valid;
    logic [31:0] out_sum;

    int checks = 0;
    int failures = 0;

    neuron_mac #(.dataWidth(16), .weightIntWidth(4), .numWeight(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .wt_wr_en   (wt_wr_en),
        .wt_wr_addr (wt_wr_addr),
        .wt_wr_data (wt_wr_data),
        .bias_wr_en (bias_wr_en),
        .bias_data  (bias_data),
        .out_valid  (out_valid),
        .out_sum    (out_sum)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_w(input logic [3:0][15:0] w);
        for (int i = 0; i < 4; i++) begin
            wt_wr_en   = 1'b1;
            wt_wr_addr = 2'(i);
            wt_wr_data = w[i];
            tick();
        end
        wt_wr_en = 1'b0;
    endtask

    task automatic set_bias(input logic [31:0] b);
        bias_wr_en = 1'b1;
        bias_data  = b;
        tick();
        bias_wr_en = 1'b0;
    endtask

    // xs[i]/gaps[i]: i-th input and idle cycles before it.
    task automatic eval(input string tag, input logic [3:0][15:0] xs, input logic [3:0][1:0] gaps,
                        input logic [31:0] exp, input bit wr_first, input bit hold);
        int n;
        for (int i = 0; i < 4; i++) begin
            repeat (int'(gaps[i])) tick();
            in_valid = 1'b1;
            in_data  = xs[i];
            if (i == 0 && wr_first) begin
                wt_wr_en   = 1'b1;
                wt_wr_addr = 2'd0;
                wt_wr_data = 16'd5;
            end
            chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
            tick();
            wt_wr_en = 1'b0;
            if (!(hold && i == 3)) in_valid = 1'b0;
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            if (hold) chk({tag, ".busy_ready"}, {31'd0, in_ready}, 32'd0);
            tick();
            n++;
        end
        if (hold) chk({tag, ".out_ready"}, {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        chk({tag, ".latency"}, 32'(n), 32'd4);
        chk({tag, ".sum"}, out_sum, exp);
        tick();
        chk({tag, ".pulse"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".hold_sum"}, out_sum, exp);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.out_sum", out_sum, 32'd0);

        set_w({16'd1, 16'd1, 16'd1, 16'd1});
        eval("ones", {16'd4, 16'd3, 16'd2, 16'd1}, '0, 32'h0000_000A, 1'b0, 1'b0);

        set_w({16'd4, 16'd3, 16'd2, 16'd1});
        eval("ramp", {16'd4, 16'd3, 16'd2, 16'd1}, '0, 32'h0000_001E, 1'b0, 1'b0);

        set_w({4{16'h7FFF}});
        eval("satpos", {4{16'h7FFF}}, '0, 32'h7FFF_FFFF, 1'b0, 1'b0);

        set_w({4{16'h8000}});
        eval("satneg", {4{16'h7FFF}}, '0, 32'h8000_0000, 1'b0, 1'b0);

        set_w({16'd1, 16'd1, 16'd1, 16'd1});
        set_bias(32'h0000_0010);
        eval("bias16", {4{16'hFFFF}}, '0, 32'h0000_000C, 1'b0, 1'b0);
        set_bias(32'h0000_0000);
        eval("bias0", {4{16'hFFFF}}, '0, 32'hFFFF_FFFC, 1'b0, 1'b0);

        // Abandon an evaluation after two accepts.
        in_valid = 1'b1;
        in_data  = 16'd7;
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst.out_sum", out_sum, 32'd0);
        eval("midrst", {16'd1, 16'd1, 16'd1, 16'd1}, '0, 32'h0000_0004, 1'b0, 1'b0);

        eval("wrdrop", {16'd4, 16'd3, 16'd2, 16'd1}, '0, 32'h0000_000A, 1'b1, 1'b1);
        eval("after", {16'd4, 16'd3, 16'd2, 16'd1}, '0, 32'h0000_000A, 1'b0, 1'b0);

        eval("gaps", {16'd4, 16'd3, 16'd2, 16'd1}, {2'd2, 2'd3, 2'd0, 2'd1}, 32'h0000_000A, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL have parameter dataWidth, default 16, the input, weight and output-slice width in bits.
REQ-002 SHALL have parameter weightIntWidth, default 4, the weight integer bits; carried for the downstream activation and not used arithmetically here.
REQ-003 SHALL have parameter numWeight, default 784, the inputs per neuron evaluation.
REQ-004 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: in_valid  in  1 / in_ready  out  1 / in_data  in  dataWidth, a signed activation input stream.
REQ-007 SHALL have ports: wt_wr_en  in  1 / wt_wr_addr  in  clog2(numWeight) / wt_wr_data  in  dataWidth, the weight load port.
REQ-008 SHALL have ports: bias_wr_en  in  1 / bias_data  in  2*dataWidth, a signed bias already in product format.
REQ-009 SHALL have ports: out_valid  out  1 / out_sum  out  2*dataWidth, the signed saturated sum, direct feed to the activation stage.

Function
REQ-010 SHALL accept an input on a rising edge with in_valid=1 and in_ready=1, using weight[in_cnt], where in_cnt counts 0..numWeight-1 and wraps to 0 after the last input.
REQ-011 SHALL run a 3-stage datapath: E+1 operands registered (weight read, 1-cycle latency), E+2 signed dataWidth x dataWidth product registered at full 2*dataWidth width, E+3 product added into the accumulator.
REQ-012 SHALL saturate every accumulator add to the signed 2*dataWidth range (max 0x7FFF_FFFF, min 0x8000_0000 at dataWidth=16); the clamp is non-sticky, so later adds start from the clamped value.
REQ-013 SHALL implement FSM ACC -> DRAIN -> BIAS -> OUT -> ACC; ACC->DRAIN on acceptance of input numWeight-1; DRAIN lasts until the last product is accumulated (edge E0+3).
REQ-014 SHALL, in BIAS (edge E0+4), load out_sum with the saturated sum of accumulator and bias register, set out_valid=1, and enter OUT.
REQ-015 SHALL hold out_valid=1 for exactly one cycle (state OUT); out_sum holds its value until the next result; the accumulator clears to 0 on the BIAS edge.
REQ-016 SHALL drive in_ready=1 only in ACC; in_valid presented in DRAIN/BIAS/OUT is ignored and not counted.
REQ-017 SHALL accept inputs with arbitrary gaps (in_valid low) without affecting the result; the pipeline advances only valid products.
REQ-018 SHALL perform a weight write only when state=ACC, in_cnt=0 and no input is accepted that edge; otherwise the write is dropped silently.
REQ-019 SHALL perform bias_wr_en writes only under the same condition as REQ-018; the bias register persists across evaluations.

Reset
REQ-020 SHALL, on rst=1 at a clock edge: state=ACC, in_cnt=0, accumulator=0, pipeline valids=0, out_valid=0, out_sum=0, bias=0; in_ready=1 from the first cycle after reset.
REQ-021 SHALL preserve weight memory contents through rst; reset mid-evaluation discards partial sums and in-flight products.

Structure
REQ-022 SHALL place the FSM state enum, the saturating-add max/min constants and the width helper in package neuron_pkg.
REQ-023 SHALL instantiate one sub-module, weight_mem: numWeight x dataWidth, one write port, one synchronous read port, 1-cycle latency.

Verification (numWeight=4, dataWidth=16)
REQ-024 SHALL cover: weights 1,1,1,1, bias 0, inputs 1,2,3,4 back-to-back -> out_sum=0x0000000A, out_valid exactly 4 edges after the last accept, one cycle wide.
REQ-025 SHALL cover: weights and inputs all 0x7FFF, bias 0 -> out_sum=0x7FFFFFFF (third add clamps, fourth stays clamped).
REQ-026 SHALL cover: weights 1, inputs 0xFFFF x4, bias 0x00000010 -> out_sum=0x0000000C; repeat with bias 0 -> 0xFFFFFFFC.
REQ-027 SHALL cover: rst asserted after 2 accepts, then inputs 1,1,1,1 with weights 1 -> out_sum=0x00000004.
REQ-028 SHALL cover: wt_wr_en (addr 0, data 5) on the same edge as the first accepted input -> write dropped, weight[0] unchanged; in_valid held high during DRAIN/BIAS/OUT -> in_ready=0 and no extra accept.
REQ-029 SHALL cover: inputs 1,2,3,4 with weights 1,1,1,1 and in_valid gaps of 0-3 cycles -> out_sum=0x0000000A.
